// File: rtl/reg_file_sequencer_pkg.sv
// Shared encodings for the register-file sequencer: opcodes, bus sources,
// FSM states and the instruction layout.
package reg_file_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MV  = 2'd0,
        OP_MVI = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_REG  = 2'd1,
        SRC_IMM  = 2'd2,
        SRC_G    = 2'd3
    } bus_src_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] rx;
        logic [1:0] ry;
    } instr_t;

    // ADD and SUB need the three-step A/G path; MV and MVI finish in T1.
    function automatic logic is_alu_op(op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/reg_file_sequencer_if.sv
// Instruction handshake plus per-cycle datapath control bundle.
interface reg_file_sequencer_if #(
    parameter int IW = 6
);
    logic          run;
    logic [IW-1:0] instr;
    logic          busy;
    logic          done;
    logic [3:0]    load;
    logic [1:0]    bus_src;
    logic [1:0]    reg_sel;
    logic          a_load;
    logic          g_load;
    logic          alu_sub;

    modport master (
        output run, instr,
        input  busy, done, load, bus_src, reg_sel, a_load, g_load, alu_sub
    );

    modport slave (
        input  run, instr,
        output busy, done, load, bus_src, reg_sel, a_load, g_load, alu_sub
    );
endinterface

// File: rtl/reg_file_sequencer_decoder_2_to_4.sv
// 2-to-4 one-hot destination decoder for register-file write enables.
module decoder_2_to_4 (
    input  logic [1:0] sel,
    output logic [3:0] onehot
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign onehot[gi] = (sel == 2'(gi));
        end
    endgenerate
endmodule

// File: rtl/reg_file_sequencer.sv
// Moore control FSM sequencing MV/MVI/ADD/SUB over a single-bus datapath;
// outputs depend only on the state and captured instruction.
module reg_file_sequencer
    import reg_file_sequencer_pkg::*;
#(
    parameter int IW = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_file_sequencer_if.slave  bus
);

    state_e        state_reg;
    logic [IW-1:0] ir_reg;
    instr_t        ir;

    assign ir = instr_t'(ir_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.run) begin
                        ir_reg    <= bus.instr;
                        state_reg <= S_T1;
                    end
                end
                S_T1:    state_reg <= is_alu_op(ir.op) ? S_T2 : S_IDLE;
                S_T2:    state_reg <= S_T3;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    logic [3:0] dest_onehot;
    logic       wr_en;
    logic       done;
    bus_src_e   bus_src;
    logic [1:0] reg_sel;
    logic       a_load;
    logic       g_load;
    logic       alu_sub;

    decoder_2_to_4 u_dest_dec (
        .sel    (ir.rx),
        .onehot (dest_onehot)
    );

    always_comb begin
        wr_en   = 1'b0;
        done    = 1'b0;
        bus_src = SRC_NONE;
        reg_sel = 2'd0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        alu_sub = 1'b0;
        case (state_reg)
            S_T1: begin
                case (ir.op)
                    OP_MV: begin
                        bus_src = SRC_REG;
                        reg_sel = ir.ry;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_src = SRC_IMM;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                    end
                    default: begin
                        bus_src = SRC_REG;
                        reg_sel = ir.rx;
                        a_load  = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                bus_src = SRC_REG;
                reg_sel = ir.ry;
                g_load  = 1'b1;
                alu_sub = (ir.op == OP_SUB);
            end
            S_T3: begin
                bus_src = SRC_G;
                wr_en   = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating the decoder output keeps load all-zero except in the write step.
    assign bus.load    = dest_onehot & {4{wr_en}};
    assign bus.busy    = (state_reg != S_IDLE);
    assign bus.done    = done;
    assign bus.bus_src = bus_src;
    assign bus.reg_sel = reg_sel;
    assign bus.a_load  = a_load;
    assign bus.g_load  = g_load;
    assign bus.alu_sub = alu_sub;

endmodule

// File: doc/reg_file_sequencer.md
# reg_file_sequencer

Multi-cycle control FSM that sequences a 4-register, single-bus datapath (register file, bus mux, A latch, ALU, G latch). It accepts one 6-bit instruction per `run` handshake and emits per-cycle control: register load enables, bus source/select, A/G latch enables and ALU mode. It sits between the instruction source (switches/test bench) and the datapath. Register-file write enables are one-hot, produced through the existing 2-to-4 destination decoder.

## Interface
Parameters:
- `IW`, 6: instruction width; fixed layout `{op[1:0], rx[1:0], ry[1:0]}` = instr[5:4], [3:2], [1:0]

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `run`  in  1  start request; sampled only in IDLE
- `instr`  in  IW  instruction; captured into internal IR on accepted `run`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse in the final step of an instruction
- `load`  out  4  one-hot register write enable (R0..R3); all-zero when no write
- `bus_src`  out  2  0=none/zero, 1=register (`reg_sel`), 2=immediate (external data), 3=G latch
- `reg_sel`  out  2  register driven on bus when `bus_src`=1
- `a_load`  out  1  latch bus into A
- `g_load`  out  1  latch ALU result into G
- `alu_sub`  out  1  ALU subtract (1) / add (0); meaningful only with `g_load`

## Operation
- Opcodes: 0 MV rx←ry; 1 MVI rx←imm; 2 ADD rx←rx+ry; 3 SUB rx←rx−ry.
- States: IDLE, T1, T2, T3 (2-bit state register). IR is a 6-bit register loaded on the edge where state=IDLE and `run`=1.
- IDLE: all control outputs 0. `run`=1 → T1 (IR←instr); else stay.
- T1: MV: `bus_src`=1, `reg_sel`=ry, `load`=onehot(rx), `done`=1 → IDLE. MVI: `bus_src`=2, `load`=onehot(rx), `done`=1 → IDLE. ADD/SUB: `bus_src`=1, `reg_sel`=rx, `a_load`=1 → T2.
- T2 (ADD/SUB only): `bus_src`=1, `reg_sel`=ry, `g_load`=1, `alu_sub`=(op==SUB) → T3.
- T3: `bus_src`=3, `load`=onehot(rx), `done`=1 → IDLE.
- Outputs are combinational functions of state and IR only (Moore); `instr` and `run` never reach outputs directly.
- `run` outside IDLE ignored; `instr` changes after capture have no effect.
- rx==ry is legal (MV R1,R1; ADD R2,R2 doubles R2).
- Arithmetic width and overflow are the ALU's concern; this block only steers.

## Timing
- Reset (async assert, any state): state=IDLE, IR=0, every output 0 immediately; in-flight instruction abandoned, no partial `load` after release.
- MV/MVI: accept edge → 1 cycle in T1 (`done`) → IDLE. Busy 1 cycle.
- ADD/SUB: T1, T2, T3 → IDLE. Busy 3 cycles; `done` in T3.
- Back-to-back: `run` held high → the IDLE cycle after `done` accepts the next instruction; minimum one IDLE cycle between instructions.
- `load` is non-zero only in the `done` cycle; never more than one bit set.

## Structure
- Shared package/header: opcode constants (OP_MV..OP_SUB), `bus_src` encodings (SRC_NONE, SRC_REG, SRC_IMM, SRC_G), state encodings.
- Sub-module: `decoder_2_to_4` converts IR.rx to one-hot; its output is ANDed with an internal write-enable to form `load`.
- Remainder: state register, IR register, one output case block.

## Test plan
- Reset mid-ADD (assert in T2): all outputs 0 same cycle, state IDLE after release, no `load` pulse.
- MVI R2 (instr=6'b01_10_00), `run` 1 cycle: next cycle `bus_src`=2, `load`=4'b0100, `done`=1, `busy`=1; following cycle all 0.
- MV R3←R1 (6'b00_11_01): T1 `bus_src`=1, `reg_sel`=1, `load`=4'b1000, `done`=1.
- SUB R0←R0−R2 (6'b11_00_10): T1 `reg_sel`=0 `a_load`=1; T2 `reg_sel`=2 `g_load`=1 `alu_sub`=1; T3 `bus_src`=3 `load`=4'b0001 `done`=1.
- `run` held high with ADD then instr changed during busy: changed value ignored; second accept exactly one IDLE cycle after `done`.
- ADD R1,R1 (6'b10_01_01): `reg_sel`=1 in both T1 and T2, `alu_sub`=0, `load`=4'b0010 in T3.
